// File: rtl/idma_axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write backend (AW + w_dp) among NumReq requesters.
// An in-order ID FIFO routes B responses back to their issuers. Optional macro: IDMA_WRITE_ARB_STATS_EN.
module idma_axi_write_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned AwWidth        = 64,
  parameter int unsigned WdpWidth       = 32,
  parameter int unsigned RspWidth       = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq*AwWidth-1:0]            req_aw_i,
  input  logic [NumReq*WdpWidth-1:0]           req_wdp_i,
  output logic [AwWidth-1:0]                   aw_o,
  output logic                                 aw_valid_o,
  input  logic                                 aw_ready_i,
  output logic [WdpWidth-1:0]                  w_dp_req_o,
  output logic                                 w_dp_valid_o,
  input  logic                                 w_dp_ready_i,
  input  logic [RspWidth-1:0]                  w_dp_rsp_i,
  input  logic                                 w_dp_rsp_valid_i,
  output logic                                 w_dp_rsp_ready_o,
  output logic [RspWidth-1:0]                  rsp_o,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 busy_o
`ifdef IDMA_WRITE_ARB_STATS_EN
  ,output logic [NumReq*32-1:0]                done_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstanding+1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding-1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq-1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d, prio_q, prio_d;
  logic            aw_done_q, aw_done_d, wdp_done_q, wdp_done_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] pick, head;
  logic            found, push, pop, empty, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == MaxCnt);
  assign head  = fifo_q[rd_ptr_q];

  // First valid requester at or above the priority pointer, cyclically.
  always_comb begin : arb
    int idx;
    logic [IdxW-1:0] cand;
    found = 1'b0;
    pick  = prio_q;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx  = (int'(prio_q) + k) % NumReq;
      cand = IdxW'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin : fsm
    logic aw_fin, wdp_fin;
    state_d      = state_q;
    grant_d      = grant_q;
    prio_d       = prio_q;
    aw_done_d    = aw_done_q;
    wdp_done_d   = wdp_done_q;
    push         = 1'b0;
    req_ready_o  = '0;
    aw_valid_o   = 1'b0;
    w_dp_valid_o = 1'b0;
    aw_o         = '0;
    w_dp_req_o   = '0;
    aw_fin       = 1'b0;
    wdp_fin      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A pop in the same cycle frees the slot, so a full FIFO may still accept.
        if (found && (!full || pop)) begin
          grant_d = pick;
          push    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        aw_o         = req_aw_i[grant_q*AwWidth +: AwWidth];
        w_dp_req_o   = req_wdp_i[grant_q*WdpWidth +: WdpWidth];
        aw_valid_o   = !aw_done_q;
        w_dp_valid_o = !wdp_done_q;
        aw_fin       = aw_done_q | aw_ready_i;
        wdp_fin      = wdp_done_q | w_dp_ready_i;
        aw_done_d    = aw_fin;
        wdp_done_d   = wdp_fin;
        if (aw_fin && wdp_fin) begin
          req_ready_o[grant_q] = 1'b1;
          prio_d     = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
          aw_done_d  = 1'b0;
          wdp_done_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_o = '0;
    if (!empty) rsp_valid_o[head] = w_dp_rsp_valid_i;
  end

  assign w_dp_rsp_ready_o = !empty && rsp_ready_i[head];
  assign pop              = w_dp_rsp_valid_i && w_dp_rsp_ready_o;
  assign rsp_o            = w_dp_rsp_i;
  assign outstanding_o    = cnt_q;
  assign busy_o           = (state_q == ISSUE) || !empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      prio_q     <= '0;
      aw_done_q  <= 1'b0;
      wdp_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      aw_done_q  <= aw_done_d;
      wdp_done_q <= wdp_done_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= pick;
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef IDMA_WRITE_ARB_STATS_EN
  logic [31:0] done_cnt_q [NumReq];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumReq; i++) done_cnt_q[i] <= '0;
    end else if (pop) begin
      done_cnt_q[head] <= done_cnt_q[head] + 32'd1;
    end
  end

  always_comb begin
    done_cnt_o = '0;
    for (int i = 0; i < NumReq; i++) done_cnt_o[i*32 +: 32] = done_cnt_q[i];
  end
`endif

endmodule

// File: doc/idma_axi_write_arbiter.md
Name: idma_axi_write_arbiter

Overview:
- Shares one AXI4 write backend (AW meta channel plus write-datapath request/response) between NumReq front-end requesters.
- Round-robin grants a requester's job and forks it onto the AW and w_dp channels.
- Tracks outstanding bursts in an in-order ID FIFO and routes each write response (B) back to the requester that issued the burst.
- Sits between the per-channel iDMA legalizers and the AXI write backend.

Parameters:
NumReq, 4, number of requesters (>=2)
MaxOutstanding, 8, depth of ID FIFO; max granted-but-unanswered bursts
AwWidth, 64, width of AW meta payload
WdpWidth, 32, width of write-datapath request payload
RspWidth, 4, width of write-datapath response payload

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  NumReq  job valid per requester
req_ready_o  out  NumReq  job accepted (one-hot pulse)
req_aw_i  in  NumReq*AwWidth  AW payload, requester i at slice i
req_wdp_i  in  NumReq*WdpWidth  w_dp payload, requester i at slice i
aw_o  out  AwWidth  AW payload to backend
aw_valid_o  out  1  AW valid
aw_ready_i  in  1  AW ready
w_dp_req_o  out  WdpWidth  w_dp request to backend
w_dp_valid_o  out  1  w_dp request valid
w_dp_ready_i  in  1  w_dp request done (backend pulses on last W beat)
w_dp_rsp_i  in  RspWidth  B response payload
w_dp_rsp_valid_i  in  1  B response valid
w_dp_rsp_ready_o  out  1  B response ready
rsp_o  out  RspWidth  response payload, broadcast to all requesters
rsp_valid_o  out  NumReq  one-hot response valid
rsp_ready_i  in  NumReq  response ready per requester
outstanding_o  out  $clog2(MaxOutstanding+1)  current FIFO fill level
busy_o  out  1  FSM in ISSUE or outstanding_o != 0

Behaviour:
- Reset:
  - FSM = IDLE, priority pointer = 0, FIFO empty, done flags cleared.
  - All valid/ready outputs 0, outstanding_o = 0, busy_o = 0.
  - Payload outputs = 0.
- FSM IDLE:
  - If any req_valid_i and outstanding_o < MaxOutstanding, pick the first valid index at or above the pointer, cyclically.
  - Register the grant index, push the index into the ID FIFO, go to ISSUE.
  - No output valids are asserted in IDLE.
- FSM ISSUE:
  - aw_o / w_dp_req_o are driven combinationally from the granted requester's slices.
  - aw_valid_o = !aw_done; w_dp_valid_o = !wdp_done.
  - An AW handshake sets aw_done; a w_dp handshake sets wdp_done. They may complete in either order or in the same cycle.
  - In the cycle the second handshake completes: req_ready_o[grant] = 1, pointer = grant+1 (mod NumReq), flags cleared, go to IDLE.
- Latency and throughput:
  - 1 cycle from req_valid_i to aw_valid_o/w_dp_valid_o.
  - Minimum 2 cycles per job.
- Requester payloads must stay stable while req_valid_i is high. The arbiter never drops a grant.
- Response path:
  - head = FIFO head index.
  - rsp_valid_o[head] = w_dp_rsp_valid_i & !empty.
  - w_dp_rsp_ready_o = rsp_ready_i[head] & !empty.
  - Pop the FIFO on w_dp_rsp_valid_i & w_dp_rsp_ready_o.
  - rsp_o = w_dp_rsp_i.
- Boundary conditions:
  - Empty FIFO with w_dp_rsp_valid_i high: hold w_dp_rsp_ready_o = 0 and drive no rsp_valid_o.
  - Push and pop in the same cycle: count unchanged. Push is allowed when full only if a pop happens the same cycle.
  - FIFO pointers wrap modulo MaxOutstanding. MaxOutstanding need not be a power of two.
- Reset mid-ISSUE returns the block to the reset state immediately (asynchronous). In-flight bursts are lost and the backend must be reset together with this block.

Optional Feature:
Macro IDMA_WRITE_ARB_STATS_EN.
- Defined: adds output port done_cnt_o (NumReq*32), one counter per requester.
  - Counter i increments on each popped response routed to requester i.
  - Wraps 0xFFFFFFFF -> 0.
  - Reset to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
1. Single job: req_valid_i=0001, aw_ready_i=1, w_dp_ready_i=1 at cycle 3.
   - aw_valid_o is high cycle 1 only.
   - w_dp_valid_o is high cycles 1-3.
   - req_ready_o=0001 at cycle 3.
   - B response 2'b00 appears on rsp_valid_o=0001.
2. Round robin: req_valid_i=1111 held, backend always ready.
   - Grant order 0,1,2,3,0.
   - req_ready_o pulses every 2 cycles.
3. Outstanding limit: 9 jobs, no B responses.
   - outstanding_o saturates at 8 and the 9th grant stalls.
   - One B handshake: 9th grant is issued the next cycle and outstanding_o stays 8.
4. Split handshakes: w_dp_ready_i at cycle 2, aw_ready_i at cycle 5.
   - aw_valid_o is held until cycle 5.
   - w_dp_valid_o drops after cycle 2.
   - req_ready_o pulses at cycle 5 only.
5. Response routing/backpressure: grants 2 then 0, responses 01 then 10, rsp_ready_i[2]=0 for 4 cycles.
   - w_dp_rsp_ready_o stays 0 for those 4 cycles.
   - Responses arrive in order: 01 to requester 2, then 10 to requester 0.
6. Reset in ISSUE after AW done, before w_dp done:
   - All outputs drop within the reset cycle.
   - outstanding_o = 0.
   - After release, the next grant starts at requester 0.
